// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel registered multiplexer with manual select and
// round-robin scan modes.
//
// Parameters:
//   WIDTH    - bits per channel
//   CHANNELS - number of input channels (>= 2)
//   SEL_W    - select width, 2**SEL_W >= CHANNELS
//   DWELL    - enabled scan cycles spent on each channel (>= 1)
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   en       - cycle enable; all state holds when low
//   mode     - 0 = manual (sel), 1 = scan
//   sel      - manual channel index
//   x        - packed inputs, channel k at [k*WIDTH +: WIDTH]
//   y        - registered selected data
//   valid    - y holds legal channel data
//   cur_sel  - channel currently addressed
//   wrap     - one-cycle pulse after scan wraps to channel 0
module mux_scan_reg #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] x,
    output logic [WIDTH-1:0]          y,
    output logic                      valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] man_data_c, scan_data_c;
    logic             man_ok_c, scan_ok_c;

    // Channel lookup for both index sources; an out-of-range index never
    // reaches the part-select, it just leaves the *_ok flag low.
    always_comb begin
        man_data_c  = '0;
        man_ok_c    = 1'b0;
        scan_data_c = '0;
        scan_ok_c   = 1'b0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (sel == SEL_W'(k)) begin
                man_data_c = x[k*WIDTH +: WIDTH];
                man_ok_c   = 1'b1;
            end
            if (cur_sel_q == SEL_W'(k)) begin
                scan_data_c = x[k*WIDTH +: WIDTH];
                scan_ok_c   = 1'b1;
            end
        end
    end

    // Next-state logic for data, select, dwell counter and wrap pulse.
    always_comb begin
        y_d       = y_q;
        valid_d   = valid_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        if (en) begin
            if (!mode) begin
                y_d       = man_data_c;
                valid_d   = man_ok_c;
                cur_sel_d = sel;
                cnt_d     = '0;
            end else if (!scan_ok_c) begin
                // Recover from an illegal select left over from manual mode.
                y_d       = '0;
                valid_d   = 1'b0;
                cur_sel_d = '0;
                cnt_d     = '0;
            end else begin
                y_d     = scan_data_c;
                valid_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (cur_sel_q == LAST_SEL) begin
                        cur_sel_d = '0;
                        wrap_d    = 1'b1;
                    end else begin
                        cur_sel_d = cur_sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            valid_q   <= 1'b0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            y_q       <= y_d;
            valid_q   <= valid_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
            cnt_q     <= cnt_d;
        end
    end

    assign y       = y_q;
    assign valid   = valid_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule
